// File: rtl/mul_share_arb_pkg.sv
// Shared definitions for mul_share_arb: FSM state encoding, default
// parameter values and the watchdog counter width.
package mul_share_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      RESP  = 2'b10,
      CLEAR = 2'b11
   } state_e;

   localparam int DEF_WIDTH   = 64;
   localparam int DEF_TIMEOUT = 80;
   localparam int TMO_CNT_W   = 7;

endpackage

// File: rtl/mul_share_arb_rr_arb2.sv
// rr_arb2: combinational two-requester round-robin arbiter with one-hot grant.
// On a collision the port opposite last_grant wins; a lone requester always wins.
module rr_arb2 (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req_valid == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end else begin
         grant = req_valid;
      end
   end

endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: shares one sequential multiplier between two requesters.
// Optional RUN watchdog enabled by defining MUL_SHARE_ARB_TIMEOUT_EN.
module mul_share_arb
   import mul_share_arb_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [WIDTH-1:0]     req_a0,
   input  logic [WIDTH-1:0]     req_b0,
   input  logic [WIDTH-1:0]     req_a1,
   input  logic [WIDTH-1:0]     req_b1,
   output logic [1:0]           resp_valid,
   input  logic [1:0]           resp_ready,
   output logic [2*WIDTH-1:0]   resp_result,
   output logic                 resp_err,
   output logic                 m_op_start,
   output logic                 m_op_clear,
   output logic [WIDTH-1:0]     m_multiplicand,
   output logic [WIDTH-1:0]     m_multiplier,
   input  logic                 m_op_done,
   input  logic [2*WIDTH-1:0]   m_result
);

   state_e               state_q, state_d;
   logic                 last_grant_q, last_grant_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic [1:0]           arb_grant;
   logic                 grant_take;
   logic                 timeout_hit;

   rr_arb2 u_rr_arb2 (
      .req_valid  (req_valid),
      .last_grant (last_grant_q),
      .grant      (arb_grant)
   );

   assign grant_take = (state_q == IDLE) && (req_valid != 2'b00);

`ifdef MUL_SHARE_ARB_TIMEOUT_EN
   logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic                 err_q, err_d;

   // Counter is zero on RUN entry, so it reads TIMEOUT-1 in the last allowed RUN cycle.
   assign timeout_hit = (state_q == RUN) && (tmo_cnt_q == TMO_CNT_W'(TIMEOUT - 1));

   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == RUN) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   always_comb begin
      err_d = err_q;
      if (state_q == RUN) begin
         if (m_op_done) begin
            err_d = 1'b0;
         end else if (timeout_hit) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
      end
   end

   assign resp_err = err_q;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT == 0);
   assign timeout_hit    = 1'b0;
   assign resp_err       = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; m_op_done outside RUN is deliberately ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid != 2'b00) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (m_op_done || timeout_hit) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready[last_grant_q]) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode; req_ready is held low while reset is asserted so no
   // requester believes a transfer happened that the FSM then discards.
   always_comb begin
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      m_op_start = 1'b0;
      m_op_clear = 1'b0;
      case (state_q)
         IDLE: begin
            if (!reset) begin
               req_ready = arb_grant;
            end
         end
         RUN: begin
            m_op_start = 1'b1;
         end
         RESP: begin
            m_op_start                 = 1'b1;
            resp_valid[last_grant_q]   = 1'b1;
         end
         CLEAR: begin
            m_op_start = 1'b1;
            m_op_clear = 1'b1;
         end
         default: begin
            m_op_start = 1'b0;
         end
      endcase
   end

   // last_grant doubles as the index of the port currently being served.
   always_comb begin
      last_grant_d = last_grant_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      result_d     = result_q;
      if (grant_take) begin
         last_grant_d = arb_grant[1];
         mcand_d      = arb_grant[1] ? req_a1 : req_a0;
         mplier_d     = arb_grant[1] ? req_b1 : req_b0;
      end
      if (state_q == RUN) begin
         if (m_op_done) begin
            result_d = m_result;
         end else if (timeout_hit) begin
            result_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         mcand_q      <= '0;
         mplier_q     <= '0;
         result_q     <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         result_q     <= result_d;
      end
   end

   assign m_multiplicand = mcand_q;
   assign m_multiplier   = mplier_q;
   assign resp_result    = result_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb with a stub sequential multiplier and
// a transaction-level reference model; define MUL_SHARE_ARB_TIMEOUT_EN for the watchdog test.
`timescale 1ns/1ps
module tb_mul_share_arb;

   localparam int W   = 64;
   localparam int TMO = 80;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [1:0]     req_valid, req_ready, resp_valid, resp_ready;
   logic [W-1:0]   req_a0, req_b0, req_a1, req_b1;
   logic [W-1:0]   m_multiplicand, m_multiplier;
   logic [2*W-1:0] resp_result, m_result;
   logic           resp_err, m_op_start, m_op_clear, m_op_done;

   int checks = 0;
   int errors = 0;
   int nresp  = 0;

   mul_share_arb #(.WIDTH(W), .TIMEOUT(TMO)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_a0         (req_a0),
      .req_b0         (req_b0),
      .req_a1         (req_a1),
      .req_b1         (req_b1),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_result    (resp_result),
      .resp_err       (resp_err),
      .m_op_start     (m_op_start),
      .m_op_clear     (m_op_clear),
      .m_multiplicand (m_multiplicand),
      .m_multiplier   (m_multiplier),
      .m_op_done      (m_op_done),
      .m_result       (m_result)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] smul(input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] x, y;
      x = {{64{a[63]}}, a};
      y = {{64{b[63]}}, b};
      return x * y;
   endfunction

   // Round-robin rule: collision goes opposite to the last grant, lone requester wins.
   function automatic logic pick(input logic [1:0] v, input logic last);
      if (v == 2'b11) return !last;
      return v[1];
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stub multiplier: done after lat cycles of start, held until start drops or clear.
   int          lat = 64;
   bit          never_done = 1'b0;
   bit          spur = 1'b0;
   int          scnt = 0;
   logic        sdone = 1'b0;
   logic [127:0] sprod = '0;

   assign m_op_done = sdone | spur;
   assign m_result  = sprod;

   always @(posedge clk) begin
      if (!m_op_start || m_op_clear) begin
         scnt  <= 0;
         sdone <= 1'b0;
      end else if (!sdone && !never_done) begin
         if (scnt >= lat - 1) begin
            sdone <= 1'b1;
            sprod <= smul(m_multiplicand, m_multiplier);
         end else begin
            scnt <= scnt + 1;
         end
      end
   end

   // Reference model: phase 0 waiting, 1 multiplying, 2 responding, 3 clearing.
   int           mph = 0;
   int           mcnt = 0;
   logic         mport = 1'b0;
   logic         mlast = 1'b1;
   logic [63:0]  ma = '0, mb = '0;
   logic [127:0] mres = '0;
   logic         merr = 1'b0;
   bit           chk_en = 1'b0;
   logic [1:0]   exp_rdy, exp_vld;

   always @(posedge clk) begin
      if (reset) begin
         mph   <= 0;
         mcnt  <= 0;
         mport <= 1'b0;
         mlast <= 1'b1;
         ma    <= '0;
         mb    <= '0;
         mres  <= '0;
         merr  <= 1'b0;
      end else begin
         case (mph)
            0: begin
               if (req_valid != 2'b00) begin
                  mport <= pick(req_valid, mlast);
                  mlast <= pick(req_valid, mlast);
                  ma    <= pick(req_valid, mlast) ? req_a1 : req_a0;
                  mb    <= pick(req_valid, mlast) ? req_b1 : req_b0;
                  mcnt  <= 0;
                  mph   <= 1;
               end
            end
            1: begin
               if (m_op_done) begin
                  mres <= smul(ma, mb);
                  merr <= 1'b0;
                  mph  <= 2;
               end
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
               else if (mcnt + 1 == TMO) begin
                  mres <= '0;
                  merr <= 1'b1;
                  mph  <= 2;
               end else begin
                  mcnt <= mcnt + 1;
               end
`endif
            end
            2: begin
               if (resp_ready[mport]) mph <= 3;
            end
            default: mph <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         exp_rdy = 2'b00;
         if (mph == 0 && !reset && req_valid != 2'b00)
            exp_rdy = pick(req_valid, mlast) ? 2'b10 : 2'b01;
         exp_vld = (mph == 2) ? (mport ? 2'b10 : 2'b01) : 2'b00;
         chk("req_ready", req_ready, exp_rdy);
         chk("resp_valid", resp_valid, exp_vld);
         chk("m_op_start", m_op_start, mph != 0);
         chk("m_op_clear", m_op_clear, mph == 3);
         chk("resp_result", resp_result, mres);
         chk("resp_err", resp_err, merr);
         chk("m_multiplicand", m_multiplicand, ma);
         chk("m_multiplier", m_multiplier, mb);
         if ((resp_valid & resp_ready) != 2'b00) nresp++;
      end
   end

   task automatic wait_resp(input int port, input int maxc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (resp_valid[port]) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_resp port %0d got no response want response within %0d cycles", port, maxc);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1, "simulation time limit");
   end

   logic [127:0] held;
   bit           seen;
   int           n;

   initial begin
      req_valid = 2'b00; resp_ready = 2'b00;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
      reset = 1'b1;
      repeat (3) tick();
      chk_en = 1'b1;
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_resp_valid", resp_valid, 2'b00);
      chk("rst_start", m_op_start, 1'b0);
      chk("rst_clear", m_op_clear, 1'b0);
      chk("rst_result", resp_result, 128'd0);
      chk("rst_mcand", m_multiplicand, 64'd0);

      // Single request on port 0: 3*5
      reset = 1'b0; req_valid = 2'b01; req_a0 = 64'd3; req_b0 = 64'd5;
      #1;
      chk("t1_grant", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      #1;
      chk("t1_ready_once", req_ready, 2'b00);
      wait_resp(0, 200);
      chk("t1_result", resp_result, 128'd15);
      resp_ready = 2'b01;
      tick();
      chk("t1_clear", m_op_clear, 1'b1);
      chk("t1_valid_drop", resp_valid, 2'b00);
      resp_ready = 2'b00;
      tick();
      chk("t1_idle", m_op_start, 1'b0);

      // Collisions from reset
      reset = 1'b1; req_valid = 2'b11;
      req_a0 = 64'd2; req_b0 = 64'd7; req_a1 = '1; req_b1 = 64'd4;
      tick();
      chk("t2_rst_ready", req_ready, 2'b00);
      reset = 1'b0;
      #1;
      chk("t2_first_p0", req_ready, 2'b01);
      tick();
      req_valid = 2'b10;
      wait_resp(0, 200);
      chk("t2_p0_result", resp_result, 128'd14);
      resp_ready = 2'b11;
      tick();
      resp_ready = 2'b00;
      tick();
      chk("t2_then_p1", req_ready, 2'b10);
      tick();
      req_valid = 2'b01; req_a0 = 64'd10; req_b0 = 64'd11;
      wait_resp(1, 200);
      chk("t2_p1_result", resp_result, -128'sd4);
      held = resp_result;
      resp_ready = 2'b01;
      for (int i = 0; i < 10; i++) begin
         chk("held_valid", resp_valid, 2'b10);
         chk("held_result", resp_result, held);
         chk("held_start", m_op_start, 1'b1);
         chk("held_clear", m_op_clear, 1'b0);
         chk("held_p0_ready", req_ready, 2'b00);
         tick();
      end
      resp_ready = 2'b10;
      tick();
      resp_ready = 2'b00; req_valid = 2'b11;
      tick();
      chk("t2_third_p0", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      wait_resp(0, 200);
      chk("t2_third_result", resp_result, 128'd110);
      resp_ready = 2'b01;
      tick();
      resp_ready = 2'b00;
      tick();

      // Reset in the middle of RUN
      req_valid = 2'b10; req_a1 = 64'd9; req_b1 = 64'd9;
      tick();
      req_valid = 2'b00;
      repeat (5) tick();
      chk("rr_running", m_op_start, 1'b1);
      reset = 1'b1;
      tick();
      chk("rr_start", m_op_start, 1'b0);
      chk("rr_ready", req_ready, 2'b00);
      chk("rr_valid", resp_valid, 2'b00);
      chk("rr_result", resp_result, 128'd0);
      chk("rr_mcand", m_multiplicand, 64'd0);
      chk("rr_mplier", m_multiplier, 64'd0);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
         if (resp_valid != 2'b00) seen = 1'b1;
         tick();
      end
      chk("rr_no_resp", seen, 1'b0);
      req_valid = 2'b01; req_a0 = 64'd6; req_b0 = -64'sd3;
      tick();
      req_valid = 2'b00;
      wait_resp(0, 200);
      chk("rr_fresh_result", resp_result, -128'sd18);
      resp_ready = 2'b01;
      tick();
      resp_ready = 2'b00;
      tick();

      // Spurious done while idle
      spur = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("spur_start", m_op_start, 1'b0);
         chk("spur_valid", resp_valid, 2'b00);
      end
      spur = 1'b0;
      tick();

`ifdef MUL_SHARE_ARB_TIMEOUT_EN
      never_done = 1'b1;
      req_valid = 2'b10; req_a1 = 64'd5; req_b1 = 64'd5;
      #1;
      chk("tmo_grant", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      n = 1;
      while (!resp_valid[1] && n < 200) begin
         tick();
         n++;
      end
      chk("tmo_cycles", n, TMO + 1);
      chk("tmo_err", resp_err, 1'b1);
      chk("tmo_result", resp_result, 128'd0);
      resp_ready = 2'b10;
      tick();
      chk("tmo_clear", m_op_clear, 1'b1);
      resp_ready = 2'b00;
      never_done = 1'b0;
      tick();
`endif

      // Randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         if (c % 300 == 0) lat = $urandom_range(1, 8);
         req_valid  = 2'($urandom_range(0, 3));
         req_a0     = {$urandom, $urandom};
         req_b0     = {$urandom, $urandom};
         req_a1     = {$urandom, $urandom};
         req_b1     = {$urandom, $urandom};
         resp_ready = 2'($urandom_range(0, 3));
         reset      = ($urandom_range(0, 199) == 0);
         spur       = (!m_op_start && $urandom_range(0, 7) == 0);
         tick();
      end
      req_valid = 2'b00; resp_ready = 2'b00; spur = 1'b0; reset = 1'b0;
      chk("rand_progress", nresp > 5, 1'b1);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
